// File: rtl/uart_loader_pkg.sv
// Shared types and address defaults for the serial program loader.
package uart_loader_pkg;

  localparam int DATA_WID = 32;

  localparam logic [DATA_WID-1:0] BASE_ADDR_DEF    = 32'h1c09_0000;
  localparam logic [DATA_WID-1:0] SCRATCH_ADDR_DEF = 32'h1c0f_fffc;

  typedef enum logic [1:0] {S_HDR, S_DATA, S_DONE} loader_state_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_loader_rx.sv
// 8N1 serial receiver: synchroniser, bit timer and deserialiser, LSB first.
module uart_loader_rx
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       stop_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_s1, rx_s2, rx_d;
  rx_state_t     state, state_next;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  assign byte_data = shreg;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RX_IDLE;
    else        state <= state_next;
  end

  // Next state: falling edge starts, mid-start re-check, 8 data bits, stop.
  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE:  if (rx_d && !rx_s2) state_next = RX_START;
      RX_START: if (cnt == HALF_LAST) state_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt == BIT_LAST && bit_idx == 3'd7) state_next = RX_STOP;
      RX_STOP:  if (cnt == BIT_LAST) state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  // Bit timer, shift register and single-cycle result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
      case (state)
        RX_START: cnt <= (cnt == HALF_LAST) ? '0 : cnt + CW'(1);
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s2, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            byte_valid <= rx_s2;
            stop_err   <= ~rx_s2;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          cnt     <= '0;
          bit_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Length-prefixed little-endian image loader feeding the core's UART memory port.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int                  CLKS_PER_BIT = 434,
  parameter logic [DATA_WID-1:0] BASE_ADDR    = BASE_ADDR_DEF,
  parameter logic [DATA_WID-1:0] SCRATCH_ADDR = SCRATCH_ADDR_DEF,
  parameter int                  MAX_WORDS    = 16384,
  parameter int                  GAP_CLKS     = 4_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                uart_rx,
  output logic [DATA_WID-1:0] uart_addr,
  output logic [DATA_WID-1:0] uart_data,
  output logic                uart_done,
  output logic                frame_err,
  output logic                len_err,
  output logic [15:0]         word_cnt
);

  localparam int GW = $clog2(GAP_CLKS + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS - 1);

  logic                byte_valid, stop_err;
  logic [7:0]          byte_data;
  loader_state_t       state, state_next;
  logic [1:0]          byte_idx, eff_idx;
  logic [23:0]         word_buf;
  logic [GW-1:0]       gap_cnt;
  logic                gap_expire, active, word_complete, hdr_too_big, hdr_zero;
  logic [DATA_WID-1:0] full_word, next_addr;
  logic [15:0]         len_n;

  uart_loader_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (uart_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .stop_err   (stop_err)
  );

  // A byte arriving on the expiry cycle restarts the word at index 0.
  assign gap_expire    = (byte_idx != 2'd0) && (gap_cnt == GAP_LAST);
  assign eff_idx       = gap_expire ? 2'd0 : byte_idx;
  assign active        = (state != S_DONE);
  assign word_complete = active && byte_valid && (eff_idx == 2'd3);
  assign full_word     = {byte_data, word_buf};
  assign hdr_too_big   = full_word > 32'(MAX_WORDS);
  assign hdr_zero      = (full_word == '0);

  // Byte assembly and inter-byte gap timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= '0;
      word_buf <= '0;
      gap_cnt  <= '0;
    end else if (active && byte_valid) begin
      gap_cnt  <= '0;
      byte_idx <= eff_idx + 2'd1;
      case (eff_idx)
        2'd0:    word_buf[7:0]   <= byte_data;
        2'd1:    word_buf[15:8]  <= byte_data;
        2'd2:    word_buf[23:16] <= byte_data;
        default: ;
      endcase
    end else if (gap_expire) begin
      byte_idx <= '0;
      gap_cnt  <= '0;
    end else if (byte_idx != 2'd0) begin
      gap_cnt <= gap_cnt + GW'(1);
    end
  end

  // Loader state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_HDR;
    else        state <= state_next;
  end

  // Next state from completed words.
  always_comb begin
    state_next = state;
    case (state)
      S_HDR:   if (word_complete && !hdr_too_big) state_next = hdr_zero ? S_DONE : S_DATA;
      S_DATA:  if (word_complete && (word_cnt + 16'd1) == len_n) state_next = S_DONE;
      S_DONE:  state_next = S_DONE;
      default: state_next = S_HDR;
    endcase
  end

  // Output port, length latch and sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_addr <= SCRATCH_ADDR;
      uart_data <= '0;
      uart_done <= 1'b0;
      frame_err <= 1'b0;
      len_err   <= 1'b0;
      word_cnt  <= '0;
      len_n     <= '0;
      next_addr <= BASE_ADDR;
    end else begin
      uart_done <= (state == S_DONE);
      if (active && stop_err) frame_err <= 1'b1;
      if (word_complete) begin
        if (state == S_HDR) begin
          if (hdr_too_big) begin
            len_err <= 1'b1;
          end else if (!hdr_zero) begin
            len_n     <= full_word[15:0];
            next_addr <= BASE_ADDR;
          end
        end else if (state == S_DATA) begin
          uart_addr <= next_addr;
          uart_data <= full_word;
          next_addr <= next_addr + 32'd4;
          word_cnt  <= word_cnt + 16'd1;
        end
      end
    end
  end

endmodule
